// File: rtl/serial_in_if.sv
// Bus bundle for the serial_in feature-memory loader: serial input, frame
// configuration, status outputs and the combinational read port.
interface serial_in_if #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned ADDR_W = 8
);
  logic              ser;
  logic [2:0]        num_dp;
  logic [4:0]        feat;
  logic              done;
  logic              word_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_data;

  modport master (
    output ser, num_dp, feat, rd_addr,
    input  done, word_valid, rd_data
  );

  modport slave (
    input  ser, num_dp, feat, rd_addr,
    output done, word_valid, rd_data
  );
endinterface

// File: rtl/serial_in.sv
// Serial-to-parallel loader: shifts 16-bit words in one bit per clock into a
// datapoint x feature array. Macro SERIAL_IN_MSB_FIRST_EN selects MSB-first words.
module serial_in (
  input  logic        CLK,
  input  logic        RST,
  serial_in_if.slave  bus
);
  localparam int unsigned WORD_W    = 16;
  localparam int unsigned MAX_DP    = 7;
  localparam int unsigned MAX_FEAT  = 32;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned MEM_DEPTH = MAX_DP * MAX_FEAT;

  typedef enum logic {LOAD = 1'b0, DONE = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_started;
  logic [2:0]         r_num_dp;
  logic [4:0]         r_feat;
  logic [3:0]         r_bit_cnt;
  logic [4:0]         r_feat_cnt;
  logic [2:0]         r_dp_cnt;
  logic [WORD_W-1:0]  r_sh;
  logic               r_done;
  logic               r_word_valid;
  logic [WORD_W-1:0]  r_mem [MEM_DEPTH];

  logic               w_word_done;
  logic               w_last_word;
  logic [WORD_W-1:0]  w_sh_nxt;
  logic [ADDR_W-1:0]  w_wr_addr;

`ifdef SERIAL_IN_MSB_FIRST_EN
  assign w_sh_nxt = {r_sh[WORD_W-2:0], bus.ser};
`else
  assign w_sh_nxt = {bus.ser, r_sh[WORD_W-1:1]};
`endif

  assign w_wr_addr = {r_dp_cnt, r_feat_cnt};

  // Next-state and word-completion decode
  always_comb begin
    w_state_nxt = r_state;
    w_word_done = 1'b0;
    w_last_word = 1'b0;
    case (r_state)
      LOAD: begin
        w_word_done = (r_bit_cnt == 4'd15);
        w_last_word = w_word_done && (r_feat_cnt == 5'd0) &&
                      (r_dp_cnt == 3'(r_num_dp - 3'd1));
        if (!r_started && (bus.num_dp == 3'd0)) begin
          w_state_nxt = DONE;
        end else if (w_last_word) begin
          w_state_nxt = DONE;
        end
      end
      DONE: w_state_nxt = DONE;
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Framing counters, configuration latch and status outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_started    <= 1'b0;
      r_num_dp     <= '0;
      r_feat       <= '0;
      r_bit_cnt    <= '0;
      r_feat_cnt   <= '0;
      r_dp_cnt     <= '0;
      r_sh         <= '0;
      r_done       <= 1'b0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= w_word_done;
      r_done       <= (w_state_nxt == DONE);
      if (r_state == LOAD) begin
        r_sh      <= w_sh_nxt;
        r_bit_cnt <= 4'(r_bit_cnt + 4'd1);
        if (!r_started) begin
          r_started  <= 1'b1;
          r_num_dp   <= bus.num_dp;
          r_feat     <= bus.feat;
          r_feat_cnt <= bus.feat;
        end else if (w_word_done) begin
          if (r_feat_cnt == 5'd0) begin
            r_feat_cnt <= r_feat;
            r_dp_cnt   <= 3'(r_dp_cnt + 3'd1);
          end else begin
            r_feat_cnt <= 5'(r_feat_cnt - 5'd1);
          end
        end
      end
    end
  end

  // Word storage; cleared by reset, written only on word completion
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_word_done) begin
      r_mem[w_wr_addr] <= w_sh_nxt;
    end
  end

  assign bus.done       = r_done;
  assign bus.word_valid = r_word_valid;
  assign bus.rd_data    = (bus.rd_addr < ADDR_W'(MEM_DEPTH)) ? r_mem[bus.rd_addr] : '0;

endmodule

// File: tb/tb_serial_in.sv
// Randomized self-checking bench for serial_in against an array-based
// reference of where every transmitted word must land.
module tb_serial_in;
  logic CLK;
  logic RST;
  serial_in_if bus ();

  serial_in dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [15:0] exp_mem [256];
  int edge_n;
  int n_valid;
  int n_bad_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given serial bit; outputs sampled 1 time unit later
  task automatic tick(input logic b);
    bus.ser = b;
    @(posedge CLK);
    #1;
    edge_n++;
    if (bus.word_valid === 1'b1) begin
      n_valid++;
      if ((edge_n % 16) != 0) n_bad_valid++;
    end
  endtask

  task automatic check_mem(input string tag);
    int bad = 0;
    int first_bad = -1;
    logic [15:0] got = '0;
    logic [15:0] want = '0;
    for (int a = 0; a < 256; a++) begin
      bus.rd_addr = 8'(a);
      #1;
      if (bus.rd_data !== exp_mem[a]) begin
        if (first_bad < 0) begin
          first_bad = a;
          got = bus.rd_data;
          want = exp_mem[a];
        end
        bad++;
      end
    end
    chk({tag, "_mem_bad_words"}, 32'(bad), 32'd0);
    if (bad != 0) $display("FAIL %s first bad addr %0d got %h expected %h", tag, first_bad, got, want);
  endtask

  task automatic do_reset(input int nd, input int ft);
    RST = 1'b0;
    bus.num_dp = 3'(nd);
    bus.feat = 5'(ft);
    repeat (3) begin
      bus.ser = 1'($urandom);
      @(posedge CLK);
      #1;
    end
    RST = 1'b1;
    for (int a = 0; a < 256; a++) exp_mem[a] = '0;
    edge_n = 0;
    n_valid = 0;
    n_bad_valid = 0;
  endtask

  // pat 0: {dp,feat} pattern, 1: random words, 2: fixed word
  task automatic run_frame(input string tag, input int nd, input int ft,
                           input int pat, input logic [15:0] fixed);
    int n_words;
    int n_early = 0;
    logic [15:0] w;
    do_reset(nd, ft);
    n_words = nd * (ft + 1);
    if (nd == 0) begin
      tick(1'($urandom));
      chk({tag, "_done_first_edge"}, 32'(bus.done), 32'd1);
    end else begin
      for (int j = 0; j < n_words; j++) begin
        int i = j / (ft + 1);
        int k = ft - (j % (ft + 1));
        case (pat)
          0: w = {8'(i), 8'(k)};
          1: w = 16'($urandom);
          default: w = fixed;
        endcase
        exp_mem[i * 32 + k] = w;
        for (int b = 0; b < 16; b++) begin
`ifdef SERIAL_IN_MSB_FIRST_EN
          tick(w[15 - b]);
`else
          tick(w[b]);
`endif
          if (edge_n == 1) begin
            bus.num_dp = 3'($urandom);
            bus.feat = 5'($urandom);
          end
          if ((edge_n < 16 * n_words) && (bus.done !== 1'b0)) n_early++;
        end
      end
      chk({tag, "_early_done"}, 32'(n_early), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd1);
      chk({tag, "_edges"}, 32'(edge_n), 32'(16 * n_words));
    end
    chk({tag, "_valid_count"}, 32'(n_valid), 32'(n_words));
    chk({tag, "_valid_misplaced"}, 32'(n_bad_valid), 32'd0);
    check_mem(tag);
  endtask

  initial begin
    int n_low;
    RST = 1'b0;
    bus.ser = 1'b0;
    bus.num_dp = '0;
    bus.feat = '0;
    bus.rd_addr = '0;

    // Reset hold with ser toggling
    do_reset(1, 0);
    RST = 1'b0;
    repeat (3) begin
      bus.ser = ~bus.ser;
      @(posedge CLK);
      #1;
    end
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_valid", 32'(bus.word_valid), 32'd0);
    check_mem("rst");

    run_frame("single", 1, 0, 2, 16'hA5C3);
    bus.rd_addr = 8'd0;
    #1;
    chk("single_mem0", 32'(bus.rd_data), 32'h0000A5C3);

    run_frame("full", 5, 11, 0, 16'h0);
    bus.rd_addr = 8'(2 * 32 + 12);
    #1;
    chk("full_slot12", 32'(bus.rd_data), 32'd0);

    // Post-done: ser ignored, memory frozen
    n_valid = 0;
    n_low = 0;
    repeat (100) begin
      tick(1'($urandom));
      if (bus.done !== 1'b1) n_low++;
    end
    chk("post_done_low", 32'(n_low), 32'd0);
    chk("post_valid", 32'(n_valid), 32'd0);
    check_mem("post");

    // Reset mid-load, checked asynchronously before any further edge
    do_reset(2, 3);
    repeat (40) tick(1'b1);
    bus.rd_addr = 8'd3;
    #1;
    chk("midload_word_stored", 32'(bus.rd_data), 32'h0000FFFF);
    #1;
    RST = 1'b0;
    #1;
    chk("async_rst_mem", 32'(bus.rd_data), 32'd0);
    chk("async_rst_valid", 32'(bus.word_valid), 32'd0);
    run_frame("fresh", 2, 3, 1, 16'h0);

    run_frame("zero_dp", 0, 7, 1, 16'h0);

    run_frame("rand_a", int'($urandom_range(1, 7)), int'($urandom_range(0, 31)), 1, 16'h0);
    run_frame("rand_b", 7, 31, 1, 16'h0);
    run_frame("rand_c", int'($urandom_range(1, 7)), int'($urandom_range(0, 5)), 1, 16'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
